// File: rtl/proc_sequencer_pkg.sv
// rtl/proc_sequencer_pkg.sv - shared types and opcode map for the 13-bit processor sequencer
package proc_sequencer_pkg;

  localparam int IW = 13;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXECUTE,
    WRITEBACK,
    HALTED
  } state_e;

  localparam logic [3:0] OP_NOP    = 4'd0;
  localparam logic [3:0] OP_ALU_LO = 4'd1;
  localparam logic [3:0] OP_ALU_HI = 4'd9;
  localparam logic [3:0] OP_HALT   = 4'd13;
  localparam logic [3:0] OP_LOAD   = 4'd14;
  localparam logic [3:0] OP_STORE  = 4'd15;

  typedef enum logic [2:0] {
    C_NOP,
    C_ALU,
    C_LOAD,
    C_STORE,
    C_HALT,
    C_ILLEGAL
  } op_class_e;

  function automatic op_class_e classify(input logic [3:0] op);
    if (op == OP_NOP)                         return C_NOP;
    else if (op >= OP_ALU_LO && op <= OP_ALU_HI) return C_ALU;
    else if (op == OP_HALT)                   return C_HALT;
    else if (op == OP_LOAD)                   return C_LOAD;
    else if (op == OP_STORE)                  return C_STORE;
    else                                      return C_ILLEGAL;
  endfunction

endpackage

// File: rtl/proc_sequencer_if.sv
// rtl/proc_sequencer_if.sv - instruction-memory and datapath control bundle of the sequencer
interface proc_sequencer_if #(
  parameter int PC_W = 4
);
  logic            start;
  logic [PC_W-1:0] imem_addr;
  logic [12:0]     imem_rdata;
  logic [2:0]      rf_raddr_a;
  logic [2:0]      rf_raddr_b;
  logic [2:0]      rf_waddr;
  logic            rf_we;
  logic            rf_wsel;
  logic [3:0]      alu_op;
  logic [3:0]      dmem_addr;
  logic            dmem_re;
  logic            dmem_we;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic            illegal;

  modport master (
    input  start, imem_rdata,
    output imem_addr, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, rf_wsel, alu_op,
           dmem_addr, dmem_re, dmem_we, pc, busy, halted, illegal
  );

  modport slave (
    output start, imem_rdata,
    input  imem_addr, rf_raddr_a, rf_raddr_b, rf_waddr, rf_we, rf_wsel, alu_op,
           dmem_addr, dmem_re, dmem_we, pc, busy, halted, illegal
  );
endinterface

// File: rtl/proc_sequencer_cu.sv
// rtl/proc_sequencer_cu.sv - control unit: splits an instruction word into fields and an opcode class
import proc_sequencer_pkg::*;

module proc_sequencer_cu (
  input  logic [12:0] ir_i,
  output logic [3:0]  opcode_o,
  output logic [2:0]  operanda_o,
  output logic [2:0]  operandb_o,
  output logic [2:0]  dest_o,
  output logic [3:0]  adrr_o,
  output op_class_e   class_o
);
  assign opcode_o   = ir_i[12:9];
  assign operanda_o = ir_i[8:6];
  assign operandb_o = ir_i[5:3];
  assign dest_o     = ir_i[2:0];
  // LOAD/STORE reuse the operand bits as a 4-bit data-memory address
  assign adrr_o     = ir_i[8:5];
  assign class_o    = classify(ir_i[12:9]);
endmodule

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - multi-cycle fetch/decode/execute/writeback sequencer driving all datapath strobes
import proc_sequencer_pkg::*;

module proc_sequencer #(
  parameter int PC_W = 4
) (
  input logic               clk,
  input logic               rst,
  proc_sequencer_if.master  bus
);
  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [12:0]     ir_q, ir_d;

  logic [3:0]  opcode, adrr;
  logic [2:0]  operanda, operandb, dest;
  op_class_e   op_class;

  logic [2:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        rf_we, rf_wsel, dmem_re, dmem_we, illegal;
  logic [3:0]  alu_op, dmem_addr;

  proc_sequencer_cu u_cu (
    .ir_i       (ir_q),
    .opcode_o   (opcode),
    .operanda_o (operanda),
    .operandb_o (operandb),
    .dest_o     (dest),
    .adrr_o     (adrr),
    .class_o    (op_class)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Every strobe is a pure decode of the registered state, so reset removes it immediately
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    rf_raddr_a = '0;
    rf_raddr_b = '0;
    rf_waddr   = '0;
    rf_we      = 1'b0;
    rf_wsel    = 1'b0;
    alu_op     = '0;
    dmem_addr  = '0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      IDLE, HALTED: if (bus.start) state_d = FETCH;
      FETCH:        state_d = DECODE;
      DECODE: begin
        ir_d    = bus.imem_rdata;
        pc_d    = pc_q + PC_W'(1);
        state_d = EXECUTE;
      end
      EXECUTE: begin
        state_d = FETCH;
        case (op_class)
          C_ALU: begin
            rf_raddr_a = operanda;
            rf_raddr_b = operandb;
            alu_op     = opcode;
            state_d    = WRITEBACK;
          end
          C_LOAD: begin
            dmem_addr = adrr;
            dmem_re   = 1'b1;
            state_d   = WRITEBACK;
          end
          C_STORE: begin
            dmem_addr  = adrr;
            rf_raddr_a = dest;
            dmem_we    = 1'b1;
          end
          C_HALT:    state_d = HALTED;
          C_ILLEGAL: illegal = 1'b1;
          default:   state_d = FETCH;
        endcase
      end
      WRITEBACK: begin
        rf_we    = 1'b1;
        rf_waddr = dest;
        rf_wsel  = (op_class == C_LOAD);
        // The ALU is combinational on the RF read ports, so keep them steady for the write
        if (op_class == C_ALU) begin
          rf_raddr_a = operanda;
          rf_raddr_b = operandb;
          alu_op     = opcode;
        end
        state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.imem_addr  = pc_q;
  assign bus.pc         = pc_q;
  assign bus.rf_raddr_a = rf_raddr_a;
  assign bus.rf_raddr_b = rf_raddr_b;
  assign bus.rf_waddr   = rf_waddr;
  assign bus.rf_we      = rf_we;
  assign bus.rf_wsel    = rf_wsel;
  assign bus.alu_op     = alu_op;
  assign bus.dmem_addr  = dmem_addr;
  assign bus.dmem_re    = dmem_re;
  assign bus.dmem_we    = dmem_we;
  assign bus.illegal    = illegal;
  assign bus.busy       = (state_q != IDLE) && (state_q != HALTED);
  assign bus.halted     = (state_q == HALTED);

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - self-checking bench for proc_sequencer with an instruction-level reference model
module tb_proc_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  proc_sequencer_if #(.PC_W(4)) bus ();
  proc_sequencer #(.PC_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [12:0] imem [16];
  always @(posedge clk) bus.imem_rdata <= imem[bus.imem_addr];

  int checks = 0;
  int failures = 0;
  logic [5:0] s;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic go();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  function automatic logic [5:0] strobes();
    return {bus.busy, bus.halted, bus.rf_we, bus.dmem_re, bus.dmem_we, bus.illegal};
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    step();
    s = strobes();
    checks++;
    if (s !== 6'b0) begin
      failures++; $display("FAIL reset_strobes got=%b exp=%b", s, 6'b0);
    end
    checks++;
    if ({bus.pc, bus.imem_addr, bus.rf_waddr, bus.dmem_addr, bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op} !== 25'd0) begin
      failures++; $display("FAIL reset_addrs pc=%0d imem=%0d waddr=%0d daddr=%0d", bus.pc, bus.imem_addr, bus.rf_waddr, bus.dmem_addr);
    end
    rst = 1'b0;
    #1;
  endtask

  task automatic test_alu();
    imem[0] = 13'b0001_001_010_011;
    imem[1] = 13'b1110_0100_00_100;
    imem[2] = 13'b1111_1100_00_101;
    imem[3] = 13'b1011_000_000_000;
    imem[4] = 13'b1101_000_000_000;
    imem[5] = 13'b0000_000_000_000;
    do_reset();
    go();
    checks++;
    if (strobes() !== 6'b100000 || bus.imem_addr !== 4'd0) begin
      failures++; $display("FAIL alu_fetch strobes=%b imem=%0d exp=100000/0", strobes(), bus.imem_addr);
    end
    step();
    step();
    checks++;
    if ({bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op} !== {3'd1, 3'd2, 4'd1} || strobes() !== 6'b100000 || bus.pc !== 4'd1) begin
      failures++; $display("FAIL alu_execute ra=%0d rb=%0d op=%0d strobes=%b pc=%0d exp=1/2/1/100000/1",
                           bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op, strobes(), bus.pc);
    end
    step();
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wsel, bus.dmem_re, bus.dmem_we} !== {1'b1, 3'd3, 1'b0, 1'b0, 1'b0}
        || {bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op} !== {3'd1, 3'd2, 4'd1}) begin
      failures++; $display("FAIL alu_writeback we=%b waddr=%0d wsel=%b ra=%0d rb=%0d op=%0d exp=1/3/0/1/2/1",
                           bus.rf_we, bus.rf_waddr, bus.rf_wsel, bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op);
    end
    step();
    checks++;
    if (strobes() !== 6'b100000 || bus.imem_addr !== 4'd1) begin
      failures++; $display("FAIL alu_next_fetch strobes=%b imem=%0d exp=100000/1", strobes(), bus.imem_addr);
    end
  endtask

  task automatic test_load();
    step();
    step();
    checks++;
    if ({bus.dmem_re, bus.dmem_we, bus.rf_we, bus.dmem_addr} !== {1'b1, 1'b0, 1'b0, 4'd4}) begin
      failures++; $display("FAIL load_execute re=%b we=%b rf_we=%b daddr=%0d exp=1/0/0/4", bus.dmem_re, bus.dmem_we, bus.rf_we, bus.dmem_addr);
    end
    step();
    checks++;
    if ({bus.rf_we, bus.rf_waddr, bus.rf_wsel, bus.dmem_re, bus.dmem_we} !== {1'b1, 3'd4, 1'b1, 1'b0, 1'b0}) begin
      failures++; $display("FAIL load_writeback we=%b waddr=%0d wsel=%b re=%b dwe=%b exp=1/4/1/0/0",
                           bus.rf_we, bus.rf_waddr, bus.rf_wsel, bus.dmem_re, bus.dmem_we);
    end
    step();
  endtask

  task automatic test_store();
    step();
    step();
    checks++;
    if ({bus.dmem_we, bus.dmem_re, bus.rf_we, bus.dmem_addr, bus.rf_raddr_a} !== {1'b1, 1'b0, 1'b0, 4'd12, 3'd5}) begin
      failures++; $display("FAIL store_execute dwe=%b re=%b rf_we=%b daddr=%0d ra=%0d exp=1/0/0/12/5",
                           bus.dmem_we, bus.dmem_re, bus.rf_we, bus.dmem_addr, bus.rf_raddr_a);
    end
    step();
    checks++;
    if (strobes() !== 6'b100000 || bus.imem_addr !== 4'd3) begin
      failures++; $display("FAIL store_three_cycles strobes=%b imem=%0d exp=100000/3", strobes(), bus.imem_addr);
    end
  endtask

  task automatic test_illegal();
    step();
    step();
    checks++;
    if (strobes() !== 6'b100001) begin
      failures++; $display("FAIL illegal_pulse strobes=%b exp=100001", strobes());
    end
    step();
    checks++;
    if (strobes() !== 6'b100000 || bus.imem_addr !== 4'd4) begin
      failures++; $display("FAIL illegal_one_cycle strobes=%b imem=%0d exp=100000/4", strobes(), bus.imem_addr);
    end
  endtask

  task automatic test_halt_resume();
    step();
    step();
    step();
    checks++;
    if (strobes() !== 6'b010000 || bus.pc !== 4'd5) begin
      failures++; $display("FAIL halt_enter strobes=%b pc=%0d exp=010000/5", strobes(), bus.pc);
    end
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (strobes() !== 6'b010000) begin
      failures++; $display("FAIL halt_hold strobes=%b exp=010000", strobes());
    end
    go();
    checks++;
    if (strobes() !== 6'b100000 || bus.imem_addr !== 4'd5) begin
      failures++; $display("FAIL halt_resume strobes=%b imem=%0d exp=100000/5", strobes(), bus.imem_addr);
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 16; i++) imem[i] = 13'd0;
    do_reset();
    go();
    for (int i = 0; i < 15; i++) begin
      step();
      step();
      step();
    end
    checks++;
    if (bus.imem_addr !== 4'd15 || strobes() !== 6'b100000) begin
      failures++; $display("FAIL wrap_fetch15 imem=%0d strobes=%b exp=15/100000", bus.imem_addr, strobes());
    end
    step();
    step();
    checks++;
    if (bus.pc !== 4'd0) begin
      failures++; $display("FAIL wrap_pc got=%0d exp=0", bus.pc);
    end
  endtask

  task automatic test_reset_mid();
    imem[0] = {4'($urandom_range(1, 9)), 9'($urandom)};
    do_reset();
    go();
    step();
    step();
    step();
    checks++;
    if (bus.rf_we !== 1'b1) begin
      failures++; $display("FAIL midreset_pre we=%b exp=1", bus.rf_we);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (strobes() !== 6'b0 || bus.pc !== 4'd0 || bus.imem_addr !== 4'd0) begin
      failures++; $display("FAIL midreset_kill strobes=%b pc=%0d exp=000000/0", strobes(), bus.pc);
    end
    step();
    rst = 1'b0;
    step();
    step();
    checks++;
    if (strobes() !== 6'b0 || bus.pc !== 4'd0) begin
      failures++; $display("FAIL midreset_idle strobes=%b pc=%0d exp=000000/0", strobes(), bus.pc);
    end
  endtask

  task automatic test_random_program();
    logic [3:0]  pc_m, op, adr;
    logic [12:0] instr;
    logic [2:0]  a, b, d;
    bit is_alu, is_load, is_store, is_halt, is_undef;
    for (int i = 0; i < 16; i++) imem[i] = 13'($urandom);
    do_reset();
    go();
    pc_m = 4'd0;
    for (int n = 0; n < 60; n++) begin
      instr    = imem[pc_m];
      op       = instr[12:9];
      a        = instr[8:6];
      b        = instr[5:3];
      d        = instr[2:0];
      adr      = instr[8:5];
      is_alu   = (op >= 4'd1 && op <= 4'd9);
      is_undef = (op >= 4'd10 && op <= 4'd12);
      is_halt  = (op == 4'd13);
      is_load  = (op == 4'd14);
      is_store = (op == 4'd15);
      checks++;
      if (strobes() !== 6'b100000 || bus.imem_addr !== pc_m) begin
        failures++; $display("FAIL rnd_fetch n=%0d strobes=%b imem=%0d exp=100000/%0d", n, strobes(), bus.imem_addr, pc_m);
      end
      step();
      checks++;
      if (strobes() !== 6'b100000) begin
        failures++; $display("FAIL rnd_decode n=%0d strobes=%b exp=100000", n, strobes());
      end
      step();
      pc_m = pc_m + 4'd1;
      checks++;
      if (strobes() !== {1'b1, 1'b0, 1'b0, is_load, is_store, is_undef} || bus.pc !== pc_m) begin
        failures++; $display("FAIL rnd_execute n=%0d op=%0d strobes=%b pc=%0d exp=%b/%0d",
                             n, op, strobes(), bus.pc, {1'b1, 1'b0, 1'b0, is_load, is_store, is_undef}, pc_m);
      end
      if (is_load || is_store) begin
        checks++;
        if (bus.dmem_addr !== adr) begin
          failures++; $display("FAIL rnd_daddr n=%0d got=%0d exp=%0d", n, bus.dmem_addr, adr);
        end
      end
      if (is_store) begin
        checks++;
        if (bus.rf_raddr_a !== d) begin
          failures++; $display("FAIL rnd_store_src n=%0d got=%0d exp=%0d", n, bus.rf_raddr_a, d);
        end
      end
      if (is_alu) begin
        checks++;
        if ({bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op} !== {a, b, op}) begin
          failures++; $display("FAIL rnd_alu_ops n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                               n, bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op, a, b, op);
        end
      end
      step();
      if (is_alu || is_load) begin
        checks++;
        if (strobes() !== 6'b101000 || {bus.rf_waddr, bus.rf_wsel} !== {d, is_load}) begin
          failures++; $display("FAIL rnd_writeback n=%0d strobes=%b waddr=%0d wsel=%b exp=101000/%0d/%b",
                               n, strobes(), bus.rf_waddr, bus.rf_wsel, d, is_load);
        end
        if (is_alu) begin
          checks++;
          if ({bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op} !== {a, b, op}) begin
            failures++; $display("FAIL rnd_alu_hold n=%0d got=%0d/%0d/%0d exp=%0d/%0d/%0d",
                                 n, bus.rf_raddr_a, bus.rf_raddr_b, bus.alu_op, a, b, op);
          end
        end
        step();
      end else if (is_halt) begin
        checks++;
        if (strobes() !== 6'b010000 || bus.pc !== pc_m) begin
          failures++; $display("FAIL rnd_halt n=%0d strobes=%b pc=%0d exp=010000/%0d", n, strobes(), bus.pc, pc_m);
        end
        go();
      end
    end
  endtask

  initial begin
    bus.start = 1'b0;
    for (int i = 0; i < 16; i++) imem[i] = 13'd0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_illegal();
    test_halt_resume();
    test_wrap();
    test_reset_mid();
    test_random_program();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
